// File: rtl/led_frame_receiver.sv
// Receive side of the 3-wire serial 7-segment link: oversample sclk/rclk/dio, rebuild 16-bit frames,
// decode segments to BCD per digit. Optional idle timeout enabled by defining LED_RX_TIMEOUT_EN.
module led_frame_receiver #(
  parameter int NUM_DIGITS  = 6,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic        clk50mhz,
  input  logic        rst_n,
  input  logic        sclk,
  input  logic        rclk,
  input  logic        dio,
  output logic [3:0]  q0,
  output logic [3:0]  q1,
  output logic [3:0]  q2,
  output logic [3:0]  q3,
  output logic [3:0]  q4,
  output logic [3:0]  q5,
  output logic [7:0]  seg_raw,
  output logic [7:0]  dig_raw,
  output logic        frame_valid,
  output logic        frame_err,
  output logic [15:0] frame_cnt,
  output logic        timeout
);

  localparam int         NUM_Q    = 6;
  localparam logic [8:0] DIG_MASK = (9'd1 << NUM_DIGITS) - 9'd1;

  function automatic logic [3:0] seg_decode(input logic [7:0] seg);
    case (seg)
      8'h03:   return 4'h0;
      8'h9F:   return 4'h1;
      8'h25:   return 4'h2;
      8'h0D:   return 4'h3;
      8'h99:   return 4'h4;
      8'h49:   return 4'h5;
      8'h41:   return 4'h6;
      8'h1F:   return 4'h7;
      8'h01:   return 4'h8;
      8'h19:   return 4'h9;
      8'hFF:   return 4'hF;
      default: return 4'hE;
    endcase
  endfunction

  // Synchronisers plus one edge register; dio is delayed alongside so it lines up with the sclk pulse.
  logic [SYNC_STAGES-1:0] sclk_sync_q, rclk_sync_q, dio_sync_q;
  logic                   sclk_last_q, rclk_last_q;
  logic                   sclk_rise_q, rclk_rise_q, dio_q;

  // NOTE: every sequential process uses non-blocking (<=) assignments so all flops see pre-edge values.
  always_ff @(posedge clk50mhz or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      rclk_sync_q <= '0;
      dio_sync_q  <= '0;
      sclk_last_q <= 1'b0;
      rclk_last_q <= 1'b0;
      sclk_rise_q <= 1'b0;
      rclk_rise_q <= 1'b0;
      dio_q       <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      rclk_sync_q <= {rclk_sync_q[SYNC_STAGES-2:0], rclk};
      dio_sync_q  <= {dio_sync_q[SYNC_STAGES-2:0], dio};
      sclk_last_q <= sclk_sync_q[SYNC_STAGES-1];
      rclk_last_q <= rclk_sync_q[SYNC_STAGES-1];
      sclk_rise_q <= sclk_sync_q[SYNC_STAGES-1] & ~sclk_last_q;
      rclk_rise_q <= rclk_sync_q[SYNC_STAGES-1] & ~rclk_last_q;
      dio_q       <= dio_sync_q[SYNC_STAGES-1];
    end
  end

  logic [15:0] sr_q, sr_d;
  logic [4:0]  bitcnt_q, bitcnt_d;
  logic [3:0]  q_q [NUM_Q];
  logic [3:0]  q_d [NUM_Q];
  logic [7:0]  seg_raw_q, seg_raw_d, dig_raw_q, dig_raw_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        valid_q, valid_d, err_q, err_d, timeout_q, timeout_d;
  logic [7:0]  seg_v, dig_v;
  logic [2:0]  k;
  logic        legal;

`ifdef LED_RX_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
  logic [IDLE_W-1:0] idle_q, idle_d;
`endif

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    sr_d        = sr_q;
    bitcnt_d    = bitcnt_q;
    q_d         = q_q;
    seg_raw_d   = seg_raw_q;
    dig_raw_d   = dig_raw_q;
    frame_cnt_d = frame_cnt_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    timeout_d   = 1'b0;
    k           = 3'd0;
`ifdef LED_RX_TIMEOUT_EN
    idle_d      = idle_q;
`endif

    if (sclk_rise_q) begin
      sr_d = {sr_q[14:0], dio_q};
      if (bitcnt_q != 5'd31) bitcnt_d = bitcnt_q + 5'd1;
    end

`ifdef LED_RX_TIMEOUT_EN
    if (sclk_rise_q) begin
      idle_d = '0;
    end else if (idle_q != IDLE_W'(TIMEOUT_CYC)) begin
      idle_d = idle_q + IDLE_W'(1);
      if (idle_d == IDLE_W'(TIMEOUT_CYC)) begin
        sr_d      = '0;
        bitcnt_d  = '0;
        timeout_d = 1'b1;
      end
    end
`endif

    // The latch works on the post-shift frame so a coincident sclk bit is included.
    for (int i = 0; i < 8; i++) seg_v[i] = sr_d[15-i];
    dig_v = sr_d[7:0];
    for (int i = 0; i < 8; i++) if (dig_v[i]) k = 3'(i);
    legal = (bitcnt_d == 5'd16) && (dig_v != 8'h00) && ((dig_v & (dig_v - 8'h01)) == 8'h00)
            && ((dig_v & ~DIG_MASK[7:0]) == 8'h00);

    if (rclk_rise_q) begin
      if (legal) begin
        if (k < 3'(NUM_Q)) q_d[k] = seg_decode(seg_v);
        seg_raw_d   = seg_v;
        dig_raw_d   = dig_v;
        frame_cnt_d = frame_cnt_q + 16'd1;
        valid_d     = 1'b1;
      end else begin
        err_d = 1'b1;
      end
      bitcnt_d = '0;
    end
  end

  // NOTE: the per-digit hold array is tiny and its reset value (blank) is visible, so it is reset.
  always_ff @(posedge clk50mhz or negedge rst_n) begin
    if (!rst_n) begin
      sr_q        <= '0;
      bitcnt_q    <= '0;
      for (int i = 0; i < NUM_Q; i++) q_q[i] <= 4'hF;
      seg_raw_q   <= 8'hFF;
      dig_raw_q   <= 8'h00;
      frame_cnt_q <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      sr_q        <= sr_d;
      bitcnt_q    <= bitcnt_d;
      q_q         <= q_d;
      seg_raw_q   <= seg_raw_d;
      dig_raw_q   <= dig_raw_d;
      frame_cnt_q <= frame_cnt_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      timeout_q   <= timeout_d;
    end
  end

`ifdef LED_RX_TIMEOUT_EN
  always_ff @(posedge clk50mhz or negedge rst_n) begin
    if (!rst_n) idle_q <= '0;
    else        idle_q <= idle_d;
  end
`endif

  assign q0          = q_q[0];
  assign q1          = q_q[1];
  assign q2          = q_q[2];
  assign q3          = q_q[3];
  assign q4          = q_q[4];
  assign q5          = q_q[5];
  assign seg_raw     = seg_raw_q;
  assign dig_raw     = dig_raw_q;
  assign frame_valid = valid_q;
  assign frame_err   = err_q;
  assign frame_cnt   = frame_cnt_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_led_frame_receiver.sv
// Directed bench for led_frame_receiver: drives the 3-wire link at 1 MHz and checks decoded outputs
// and pulse counts against hand-computed values.
module tb_led_frame_receiver;

  logic        clk50mhz = 1'b0;
  logic        rst_n    = 1'b0;
  logic        sclk     = 1'b0;
  logic        rclk     = 1'b0;
  logic        dio      = 1'b0;
  logic [3:0]  q0, q1, q2, q3, q4, q5;
  logic [7:0]  seg_raw, dig_raw;
  logic        frame_valid, frame_err, timeout;
  logic [15:0] frame_cnt;

  int nvec = 0;
  int nerr = 0;
  int nvalid = 0, nfe = 0, nto = 0;
  int v0, e0, t0;

  led_frame_receiver dut (
    .clk50mhz    (clk50mhz),
    .rst_n       (rst_n),
    .sclk        (sclk),
    .rclk        (rclk),
    .dio         (dio),
    .q0          (q0),
    .q1          (q1),
    .q2          (q2),
    .q3          (q3),
    .q4          (q4),
    .q5          (q5),
    .seg_raw     (seg_raw),
    .dig_raw     (dig_raw),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .frame_cnt   (frame_cnt),
    .timeout     (timeout)
  );

  always #10 clk50mhz = ~clk50mhz;

  always @(negedge clk50mhz) begin
    if (frame_valid === 1'b1) nvalid++;
    if (frame_err   === 1'b1) nfe++;
    if (timeout     === 1'b1) nto++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wire word: seg[0] goes out first, dig[0] last.
  function automatic logic [15:0] make_frame(input logic [7:0] seg, input logic [7:0] dig);
    logic [7:0] rev;
    for (int i = 0; i < 8; i++) rev[7-i] = seg[i];
    return {rev, dig};
  endfunction

  task automatic send_bits(input logic [15:0] word, input int n);
    for (int i = 0; i < n; i++) begin
      dio = word[15-i];
      #200 sclk = 1'b1;
      #500 sclk = 1'b0;
      #300;
    end
  endtask

  task automatic pulse_rclk();
    #200 rclk = 1'b1;
    #500 rclk = 1'b0;
    #500;
  endtask

  task automatic send_frame(input logic [7:0] seg, input logic [7:0] dig);
    send_bits(make_frame(seg, dig), 16);
    pulse_rclk();
  endtask

  task automatic snap();
    v0 = nvalid;
    e0 = nfe;
    t0 = nto;
  endtask

  initial begin
    // 1. Reset state
    #95;
    check("rst_q0", 32'(q0), 32'hF);
    check("rst_q5", 32'(q5), 32'hF);
    check("rst_seg_raw", 32'(seg_raw), 32'hFF);
    check("rst_dig_raw", 32'(dig_raw), 32'h00);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_pulses", {29'd0, frame_valid, frame_err, timeout}, 32'd0);
    rst_n = 1'b1;
    #100;

    // 2. Single frame: '7' on digit 3
    snap();
    send_frame(8'h1F, 8'h08);
    check("t2_q3", 32'(q3), 32'h7);
    check("t2_q0", 32'(q0), 32'hF);
    check("t2_q4", 32'(q4), 32'hF);
    check("t2_cnt", 32'(frame_cnt), 32'd1);
    check("t2_valid", 32'(nvalid - v0), 32'd1);
    check("t2_err", 32'(nfe - e0), 32'd0);
    check("t2_seg_raw", 32'(seg_raw), 32'h1F);
    check("t2_dig_raw", 32'(dig_raw), 32'h08);

    // 3. Digits 0..5 show 1..6
    snap();
    send_frame(8'h9F, 8'h01);
    send_frame(8'h25, 8'h02);
    send_frame(8'h0D, 8'h04);
    send_frame(8'h99, 8'h08);
    send_frame(8'h49, 8'h10);
    send_frame(8'h41, 8'h20);
    check("t3_q", {8'd0, q5, q4, q3, q2, q1, q0}, 32'h00654321);
    check("t3_cnt", 32'(frame_cnt), 32'd7);
    check("t3_valid", 32'(nvalid - v0), 32'd6);
    check("t3_err", 32'(nfe - e0), 32'd0);

    // 4. Rejected frames: short frame, non-one-hot dig, digit beyond NUM_DIGITS
    snap();
    send_bits(make_frame(8'h01, 8'h01), 15);
    pulse_rclk();
    check("t4_short_err", 32'(nfe - e0), 32'd1);
    check("t4_short_q0", 32'(q0), 32'h1);
    snap();
    send_frame(8'h01, 8'h0C);
    check("t4_0c_err", 32'(nfe - e0), 32'd1);
    snap();
    send_frame(8'h01, 8'h40);
    check("t4_40_err", 32'(nfe - e0), 32'd1);
    check("t4_valid", 32'(nvalid - v0), 32'd0);
    check("t4_cnt", 32'(frame_cnt), 32'd7);
    check("t4_raw", {16'd0, seg_raw, dig_raw}, 32'h4120);
    check("t4_q", {8'd0, q5, q4, q3, q2, q1, q0}, 32'h00654321);

    // 5. Bad pattern -> E, blank -> F, both accepted
    snap();
    send_frame(8'h55, 8'h01);
    check("t5_bad_q0", 32'(q0), 32'hE);
    check("t5_bad_valid", 32'(nvalid - v0), 32'd1);
    snap();
    send_frame(8'hFF, 8'h02);
    check("t5_blank_q1", 32'(q1), 32'hF);
    check("t5_blank_valid", 32'(nvalid - v0), 32'd1);
    check("t5_cnt", 32'(frame_cnt), 32'd9);
    check("t5_raw", {16'd0, seg_raw, dig_raw}, 32'hFF02);

    // 6. Partial frame followed by a long idle gap, then a full frame
    snap();
    send_bits(16'hFFFF, 7);
    repeat (5000) @(posedge clk50mhz);
    send_frame(8'h9F, 8'h01);
`ifdef LED_RX_TIMEOUT_EN
    check("t6_timeout", 32'(nto - t0), 32'd1);
    check("t6_err", 32'(nfe - e0), 32'd0);
    check("t6_q0", 32'(q0), 32'h1);
    check("t6_cnt", 32'(frame_cnt), 32'd10);
`else
    check("t6_timeout", 32'(nto - t0), 32'd0);
    check("t6_err", 32'(nfe - e0), 32'd1);
    check("t6_q0", 32'(q0), 32'hE);
    check("t6_cnt", 32'(frame_cnt), 32'd9);
`endif

    // 7. Reset mid-frame discards the partial frame
    send_bits(make_frame(8'h01, 8'h01), 5);
    rst_n = 1'b0;
    #100;
    check("t7_rst_cnt", 32'(frame_cnt), 32'd0);
    check("t7_rst_q", {8'd0, q5, q4, q3, q2, q1, q0}, 32'h00FFFFFF);
    rst_n = 1'b1;
    #100;
    snap();
    send_frame(8'h19, 8'h20);
    check("t7_q5", 32'(q5), 32'h9);
    check("t7_cnt", 32'(frame_cnt), 32'd1);
    check("t7_valid", 32'(nvalid - v0), 32'd1);
    check("t7_err", 32'(nfe - e0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
